// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the load/store memory access controller.
//   - default word / word-address widths
//   - request size encodings
//   - controller FSM state type
//   - alignment check helper used when MEM_ACCESS_ALIGN_CHK_EN is defined
package mem_pkg;

    localparam int MEM_DATA_W = 32;
    localparam int MEM_ADDR_W = 15;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RSP  = 3'd4
    } state_t;

    // True when the access size cannot be served at the given byte offset,
    // or when the size encoding is the reserved one.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for 32-bit little-endian words.
//   old_word  in  32 : word read from memory
//   wdata     in  32 : right-justified store data
//   size      in  2  : access size (byte/half/word; reserved treated as word)
//   addr_lo   in  2  : byte offset within the word
//   sext      in  1  : sign-extend sub-word loads
//   new_word  out 32 : old_word with the store lanes replaced
//   load_data out 32 : selected lane(s) of old_word, sign- or zero-extended
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sext,
    output logic [31:0] new_word,
    output logic [31:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store merge: replace only the addressed lane(s); a half store uses addr[1] only.
    always_comb begin
        new_word = old_word;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'd0:    new_word[7:0]   = wdata[7:0];
                    2'd1:    new_word[15:8]  = wdata[7:0];
                    2'd2:    new_word[23:16] = wdata[7:0];
                    2'd3:    new_word[31:24] = wdata[7:0];
                    default: new_word        = old_word;
                endcase
            end
            SZ_HALF: begin
                if (addr_lo[1]) begin
                    new_word[31:16] = wdata[15:0];
                end else begin
                    new_word[15:0]  = wdata[15:0];
                end
            end
            default: new_word = wdata;
        endcase
    end

    // Load extract: pick the lane, then extend from its top bit when signed.
    always_comb begin
        byte_s    = old_word[7:0];
        half_s    = old_word[15:0];
        load_data = old_word;
        case (addr_lo)
            2'd0:    byte_s = old_word[7:0];
            2'd1:    byte_s = old_word[15:8];
            2'd2:    byte_s = old_word[23:16];
            2'd3:    byte_s = old_word[31:24];
            default: byte_s = old_word[7:0];
        endcase
        if (addr_lo[1]) begin
            half_s = old_word[31:16];
        end else begin
            half_s = old_word[15:0];
        end
        case (size)
            SZ_BYTE: load_data = {{24{sext & byte_s[7]}}, byte_s};
            SZ_HALF: load_data = {{16{sext & half_s[15]}}, half_s};
            default: load_data = old_word;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte-addressed load/store initiator for a single-port word
// memory with a 1-cycle registered read. Sub-word stores use read-modify-write.
// Optional macro: MEM_ACCESS_ALIGN_CHK_EN enables misalignment / reserved-size
// errors; without it low address bits below the access size are ignored and
// size 11 behaves as a word access.
// Ports:
//   clka, rsta_n                         : clock, synchronous active-low reset
//   req_valid/req_ready                  : request handshake
//   req_we, req_size, req_signed,
//   req_addr, req_wdata                  : request fields
//   rsp_valid, rsp_rdata, rsp_err        : one-cycle response pulse
//   mem_we, mem_addr, mem_din, mem_dout  : memory port (wea/addra/dina/douta)
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int DATA = MEM_DATA_W,
    parameter int ADDR = MEM_ADDR_W
) (
    input  logic            clka,
    input  logic            rsta_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_signed,
    input  logic [ADDR+1:0] req_addr,
    input  logic [DATA-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [DATA-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            mem_we,
    output logic [ADDR-1:0] mem_addr,
    output logic [DATA-1:0] mem_din,
    input  logic [DATA-1:0] mem_dout
);

    state_t          state_r;
    logic            req_ready_r;
    logic            rsp_valid_r;
    logic            rsp_err_r;
    logic [DATA-1:0] rsp_rdata_r;
    logic            mem_we_r;
    logic [ADDR-1:0] mem_addr_r;
    logic [DATA-1:0] mem_din_r;

    // Latched request fields (word address lives in mem_addr_r)
    logic            we_r;
    logic [1:0]      size_r;
    logic            sext_r;
    logic [1:0]      addr_lo_r;
    logic [DATA-1:0] wdata_r;

    logic            err_s;
    logic [DATA-1:0] merged_s;
    logic [DATA-1:0] extracted_s;

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_rdata = rsp_rdata_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_din   = mem_din_r;

    // Request error decode (only meaningful on the accept edge).
    always_comb begin
`ifdef MEM_ACCESS_ALIGN_CHK_EN
        err_s = is_misaligned(req_size, req_addr[1:0]);
`else
        err_s = 1'b0;
`endif
    end

    // Lane steering works directly on douta during CAP so the merged word and
    // extracted load data are captured into the output registers on that edge.
    mem_lane_align u_lane (
        .old_word  (mem_dout),
        .wdata     (wdata_r),
        .size      (size_r),
        .addr_lo   (addr_lo_r),
        .sext      (sext_r),
        .new_word  (merged_s),
        .load_data (extracted_s)
    );

    // Controller FSM with request latch and registered outputs.
    always_ff @(posedge clka) begin
        if (!rsta_n) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= {DATA{1'b0}};
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR{1'b0}};
            mem_din_r   <= {DATA{1'b0}};
            we_r        <= 1'b0;
            size_r      <= SZ_BYTE;
            sext_r      <= 1'b0;
            addr_lo_r   <= 2'b00;
            wdata_r     <= {DATA{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        we_r        <= req_we;
                        size_r      <= req_size;
                        sext_r      <= req_signed;
                        addr_lo_r   <= req_addr[1:0];
                        wdata_r     <= req_wdata;
                        req_ready_r <= 1'b0;
                        if (err_s) begin
                            // No memory cycle: mem_addr keeps its previous value.
                            state_r     <= ST_RSP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                            rsp_rdata_r <= {DATA{1'b0}};
                        end else if (req_we && req_size[1]) begin
                            // Full-word store (size 11 only reaches here unchecked).
                            state_r    <= ST_WR;
                            mem_addr_r <= req_addr[ADDR+1:2];
                            mem_we_r   <= 1'b1;
                            mem_din_r  <= req_wdata;
                        end else begin
                            state_r    <= ST_RD;
                            mem_addr_r <= req_addr[ADDR+1:2];
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ST_RD: begin
                    state_r <= ST_CAP;
                end
                ST_CAP: begin
                    if (we_r) begin
                        state_r   <= ST_WR;
                        mem_we_r  <= 1'b1;
                        mem_din_r <= merged_s;
                    end else begin
                        state_r     <= ST_RSP;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b0;
                        rsp_rdata_r <= extracted_s;
                    end
                end
                ST_WR: begin
                    state_r     <= ST_RSP;
                    mem_we_r    <= 1'b0;
                    mem_din_r   <= {DATA{1'b0}};
                    rsp_valid_r <= 1'b1;
                    rsp_err_r   <= 1'b0;
                    rsp_rdata_r <= {DATA{1'b0}};
                end
                ST_RSP: begin
                    state_r     <= ST_IDLE;
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    rsp_rdata_r <= {DATA{1'b0}};
                    req_ready_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    mem_we_r    <= 1'b0;
                    mem_din_r   <= {DATA{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed self-checking bench for mem_access_ctrl with a
// behavioural single-port RAM (1-cycle registered read). Honours
// MEM_ACCESS_ALIGN_CHK_EN for the misaligned-access expectations.
module tb_mem_access_ctrl;

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] W = 2'b10;

    logic        clka;
    logic        rsta_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [16:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    logic [31:0] ram [0:32767];

    int checks = 0;
    int errors = 0;

    mem_access_ctrl dut (
        .clka       (clka),
        .rsta_n     (rsta_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    initial begin
        clka = 1'b0;
        forever #5 clka = ~clka;
    end

    always @(posedge clka) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge; on return we are in cycle 1.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [16:0] addr, input logic [31:0] wdata);
        chk("ready_before_issue", {31'd0, req_ready}, 32'd1);
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic store_word(input logic [16:0] addr, input logic [31:0] data);
        issue(1'b1, W, 1'b0, addr, data);
        chk("wst_we_c1", {31'd0, mem_we}, 32'd1);
        chk("wst_addr_c1", {17'd0, mem_addr}, {17'd0, addr[16:2]});
        chk("wst_din_c1", mem_din, data);
        tick();
        chk("wst_rsp_c2", {31'd0, rsp_valid}, 32'd1);
        chk("wst_we_c2", {31'd0, mem_we}, 32'd0);
        tick();
    endtask

    task automatic store_sub(input string tag, input logic [1:0] size, input logic [16:0] addr,
                             input logic [31:0] data, input logic [31:0] exp_din);
        issue(1'b1, size, 1'b0, addr, data);
        chk({tag, "_we_c1"}, {31'd0, mem_we}, 32'd0);
        tick();
        chk({tag, "_we_c2"}, {31'd0, mem_we}, 32'd0);
        tick();
        chk({tag, "_we_c3"}, {31'd0, mem_we}, 32'd1);
        chk({tag, "_din_c3"}, mem_din, exp_din);
        chk({tag, "_rsp_c3"}, {31'd0, rsp_valid}, 32'd0);
        tick();
        chk({tag, "_rsp_c4"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_rdata_c4"}, rsp_rdata, 32'd0);
        tick();
    endtask

    task automatic load_chk(input string tag, input logic [1:0] size, input logic sgn,
                            input logic [16:0] addr, input logic [31:0] exp);
        issue(1'b0, size, sgn, addr, 32'd0);
        chk({tag, "_rsp_c1"}, {31'd0, rsp_valid}, 32'd0);
        tick();
        chk({tag, "_rsp_c2"}, {31'd0, rsp_valid}, 32'd0);
        tick();
        chk({tag, "_rsp_c3"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_err_c3"}, {31'd0, rsp_err}, 32'd0);
        chk({tag, "_rdata"}, rsp_rdata, exp);
        tick();
        chk({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int acc;
        int nrsp;
        int acc_cyc [3];
        logic [16:0] q_addr [3];
        logic [1:0]  q_size [3];
        logic        q_sgn  [3];
        logic [31:0] q_exp  [3];

        rsta_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = B;
        req_signed = 1'b0; req_addr = 17'd0; req_wdata = 32'd0;
        tick(); tick();
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {17'd0, mem_addr}, 32'd0);
        chk("rst_mem_din", mem_din, 32'd0);
        rsta_n = 1'b1;
        tick();
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Word store then word load
        store_word(17'h40, 32'hDEADBEEF);
        chk("idle_ready", {31'd0, req_ready}, 32'd1);
        load_chk("ld_word", W, 1'b0, 17'h40, 32'hDEADBEEF);

        // Byte store via read-modify-write
        store_word(17'h40, 32'h11223344);
        store_sub("st_byte", B, 17'h41, 32'h123456AB, 32'h1122AB44);
        load_chk("ld_after_byte", W, 1'b0, 17'h40, 32'h1122AB44);

        // Extension rules
        store_word(17'h40, 32'h80F07F22);
        load_chk("ld_sb_43", B, 1'b1, 17'h43, 32'hFFFFFF80);
        load_chk("ld_ub_43", B, 1'b0, 17'h43, 32'h00000080);
        load_chk("ld_sh_42", H, 1'b1, 17'h42, 32'hFFFF80F0);
        load_chk("ld_sb_41", B, 1'b1, 17'h41, 32'h0000007F);
        load_chk("ld_sw_40", W, 1'b1, 17'h40, 32'h80F07F22);

        // Half store into upper lane pair
        store_sub("st_half", H, 17'h42, 32'hFFFF1234, 32'h12347F22);
        load_chk("ld_after_half", W, 1'b0, 17'h40, 32'h12347F22);

`ifdef MEM_ACCESS_ALIGN_CHK_EN
        issue(1'b0, H, 1'b0, 17'h41, 32'd0);
        chk("mis_half_rsp_c1", {31'd0, rsp_valid}, 32'd1);
        chk("mis_half_err_c1", {31'd0, rsp_err}, 32'd1);
        chk("mis_half_rdata", rsp_rdata, 32'd0);
        chk("mis_half_we", {31'd0, mem_we}, 32'd0);
        tick();
        chk("mis_half_idle", {31'd0, rsp_valid}, 32'd0);
        issue(1'b1, 2'b11, 1'b0, 17'h40, 32'hFFFFFFFF);
        chk("rsvd_err_c1", {31'd0, rsp_err}, 32'd1);
        chk("rsvd_we_c1", {31'd0, mem_we}, 32'd0);
        tick();
        load_chk("ld_after_err", W, 1'b0, 17'h40, 32'h12347F22);
`else
        load_chk("ld_half_41_noalign", H, 1'b0, 17'h41, 32'h00007F22);
        load_chk("ld_word_43_noalign", W, 1'b0, 17'h43, 32'h12347F22);
`endif

        // Reset asserted while the sub-word store is in WR
        issue(1'b1, B, 1'b0, 17'h44, 32'h00000055);
        tick(); tick();
        chk("abort_we_in_wr", {31'd0, mem_we}, 32'd1);
        rsta_n = 1'b0;
        tick();
        chk("abort_we_after", {31'd0, mem_we}, 32'd0);
        chk("abort_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("abort_ready_low", {31'd0, req_ready}, 32'd0);
        rsta_n = 1'b1;
        tick();
        chk("abort_rsp_after", {31'd0, rsp_valid}, 32'd0);
        chk("abort_ready_after", {31'd0, req_ready}, 32'd1);

        // req_valid held high across three loads
        q_addr[0] = 17'h40; q_size[0] = W; q_sgn[0] = 1'b0; q_exp[0] = 32'h12347F22;
        q_addr[1] = 17'h41; q_size[1] = B; q_sgn[1] = 1'b1; q_exp[1] = 32'h0000007F;
        q_addr[2] = 17'h42; q_size[2] = H; q_sgn[2] = 1'b0; q_exp[2] = 32'h00001234;
        acc = 0; nrsp = 0;
        req_we = 1'b0; req_size = q_size[0]; req_signed = q_sgn[0]; req_addr = q_addr[0];
        req_valid = 1'b1;
        for (int c = 0; c < 40 && nrsp < 3; c++) begin
            logic accepting;
            accepting = req_valid & req_ready;
            if (accepting) chk("hold_no_overlap", acc, nrsp);
            tick();
            if (rsp_valid) begin
                chk("hold_rdata", rsp_rdata, q_exp[nrsp]);
                chk("hold_latency", c - acc_cyc[nrsp], 32'd2);
                chk("hold_ready_in_rsp", {31'd0, req_ready}, 32'd0);
                nrsp++;
            end
            if (accepting) begin
                acc_cyc[acc] = c;
                acc++;
                if (acc < 3) begin
                    req_size = q_size[acc]; req_signed = q_sgn[acc]; req_addr = q_addr[acc];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        chk("hold_accepts", acc, 32'd3);
        chk("hold_responses", nrsp, 32'd3);
        tick(); tick();
        chk("hold_no_extra_rsp", {31'd0, rsp_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
